// File: rtl/n64a_deblur_sched.sv
// Frame-synchronous scheduler for the VI-deblur estimator: double-buffers settings,
// applies them at frame start, issues algorithm resets and gates estimator runs.
module n64a_deblur_sched #(
    parameter int SETTLE_FRAMES = 2,
    parameter int RST_LEN       = 4
) (
    input  logic        VCLK,
    input  logic        nRST,
    input  logic        nVDSYNC,
    input  logic        nVSYNC_i,
    input  logic        n64_480i,
    input  logic        cfg_wr_i,
    input  logic [15:0] cfg_data_i,
    output logic        cfg_pending_o,
    output logic [15:0] settings_o,
    output logic        nrst_alg_o,
    output logic        est_enable_o,
    output logic [7:0]  frame_cnt_o
);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Settings bits that change what the estimator accumulates.
    localparam logic [15:0] RELEVANT_MASK = 16'h7F3C;
    localparam logic [3:0]  SETTLE_LAST   = 4'(SETTLE_FRAMES - 1);
    localparam logic [3:0]  RST_LOAD      = 4'(RST_LEN);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  settle_cnt;
    logic [3:0]  settle_cnt_nx;
    logic [3:0]  rst_cnt;
    logic [15:0] shadow;
    logic        vsync_q;
    logic        fe;
    logic        apply;
    logic        relevant;
    logic        hold_to_settle;
    logic        alg_req;
    logic        est_enable_nx;
    logic [7:0]  frame_cnt_nx;

    assign fe       = ~nVDSYNC & vsync_q & ~nVSYNC_i;
    assign apply    = fe & cfg_pending_o;
    assign relevant = apply & (|((shadow ^ settings_o) & RELEVANT_MASK));
    assign alg_req  = relevant | hold_to_settle;

    // Sync sampling, settings double-buffer and algorithm-reset pulse.
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            vsync_q       <= 1'b1;
            shadow        <= 16'h0000;
            settings_o    <= 16'h0000;
            cfg_pending_o <= 1'b0;
            rst_cnt       <= RST_LOAD;
            nrst_alg_o    <= 1'b0;
        end else begin
            if (!nVDSYNC) vsync_q <= nVSYNC_i;
            if (cfg_wr_i) shadow <= cfg_data_i;
            if (apply) settings_o <= shadow;
            if (cfg_wr_i) cfg_pending_o <= 1'b1;
            else if (fe) cfg_pending_o <= 1'b0;
            if (alg_req) begin
                rst_cnt    <= RST_LOAD;
                nrst_alg_o <= 1'b0;
            end else if (rst_cnt != 4'd0) begin
                rst_cnt    <= rst_cnt - 4'd1;
                nrst_alg_o <= (rst_cnt == 4'd1);
            end
        end
    end

    // FSM state register and its registered outputs.
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            state        <= ST_HOLD;
            settle_cnt   <= 4'd0;
            est_enable_o <= 1'b0;
            frame_cnt_o  <= 8'h00;
        end else begin
            state        <= state_nx;
            settle_cnt   <= settle_cnt_nx;
            est_enable_o <= est_enable_nx;
            frame_cnt_o  <= frame_cnt_nx;
        end
    end

    // Interlace forces HOLD; a relevant change restarts settling before counting.
    always_comb begin
        state_nx       = state;
        settle_cnt_nx  = settle_cnt;
        hold_to_settle = 1'b0;
        if (n64_480i) begin
            state_nx = ST_HOLD;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (fe) begin
                        state_nx       = ST_SETTLE;
                        settle_cnt_nx  = 4'd0;
                        hold_to_settle = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (relevant) begin
                        settle_cnt_nx = 4'd0;
                    end else if (fe) begin
                        if (settle_cnt == SETTLE_LAST) state_nx = ST_RUN;
                        else settle_cnt_nx = settle_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (relevant) begin
                        state_nx      = ST_SETTLE;
                        settle_cnt_nx = 4'd0;
                    end
                end
                default: state_nx = ST_HOLD;
            endcase
        end
    end

    always_comb begin
        est_enable_nx = (state_nx == ST_RUN);
        frame_cnt_nx  = frame_cnt_o;
        if (state == ST_SETTLE && state_nx == ST_RUN) begin
            frame_cnt_nx = 8'h00;
        end else if (state == ST_RUN && state_nx == ST_RUN && fe && frame_cnt_o != 8'hFF) begin
            frame_cnt_nx = frame_cnt_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_n64a_deblur_sched.sv
// Bench for n64a_deblur_sched: frame-level reference model feeding an expected queue,
// checked every cycle by an independent monitor, plus directed scenario checks.
`timescale 1ns/1ps
module tb_n64a_deblur_sched;
  localparam int SETTLE_FRAMES = 2;
  localparam int RST_LEN = 4;
  localparam int W = 27;
  localparam int M_HOLD = 0;
  localparam int M_SETTLE = 1;
  localparam int M_RUN = 2;

  // clock / reset
  logic VCLK = 1'b0;
  logic nRST = 1'b0;
  logic nVDSYNC = 1'b1;
  logic nVSYNC_i = 1'b1;
  logic n64_480i = 1'b0;
  logic cfg_wr_i = 1'b0;
  logic [15:0] cfg_data_i = 16'h0000;
  logic cfg_pending_o;
  logic [15:0] settings_o;
  logic nrst_alg_o;
  logic est_enable_o;
  logic [7:0] frame_cnt_o;

  always #5 VCLK = ~VCLK;

  n64a_deblur_sched #(.SETTLE_FRAMES(SETTLE_FRAMES), .RST_LEN(RST_LEN)) dut (
    .VCLK(VCLK),
    .nRST(nRST),
    .nVDSYNC(nVDSYNC),
    .nVSYNC_i(nVSYNC_i),
    .n64_480i(n64_480i),
    .cfg_wr_i(cfg_wr_i),
    .cfg_data_i(cfg_data_i),
    .cfg_pending_o(cfg_pending_o),
    .settings_o(settings_o),
    .nrst_alg_o(nrst_alg_o),
    .est_enable_o(est_enable_o),
    .frame_cnt_o(frame_cnt_o)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge VCLK) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cfg_pending_o", {15'd0, cfg_pending_o}, {15'd0, e[26]});
      check("settings_o", settings_o, e[25:10]);
      check("nrst_alg_o", {15'd0, nrst_alg_o}, {15'd0, e[9]});
      check("est_enable_o", {15'd0, est_enable_o}, {15'd0, e[8]});
      check("frame_cnt_o", {8'd0, frame_cnt_o}, {8'd0, e[7:0]});
    end
  end

  // reference model: frame-level view of the scheduler
  bit m_vs;
  bit m_pending;
  logic [15:0] m_shadow;
  logic [15:0] m_settings;
  int m_mode;
  int m_left;
  int m_frames;
  int m_pulse;

  function automatic void model_reset();
    m_vs = 1'b1;
    m_pending = 1'b0;
    m_shadow = 16'h0000;
    m_settings = 16'h0000;
    m_mode = M_HOLD;
    m_left = 0;
    m_frames = 0;
    m_pulse = RST_LEN;
  endfunction

  function automatic logic [W-1:0] model_out();
    return {m_pending, m_settings, (m_pulse == 0), (m_mode == M_RUN), 8'(m_frames)};
  endfunction

  function automatic void model_edge();
    bit fe;
    bit app;
    bit rel;
    bit req;
    fe = !nVDSYNC && m_vs && !nVSYNC_i;
    if (!nVDSYNC) m_vs = nVSYNC_i;
    app = fe && m_pending;
    rel = app && (((m_settings ^ m_shadow) & 16'h7F3C) != 16'h0000);
    req = rel;
    if (app) m_settings = m_shadow;
    if (cfg_wr_i) begin
      m_shadow = cfg_data_i;
      m_pending = 1'b1;
    end else if (fe) begin
      m_pending = 1'b0;
    end
    if (n64_480i) begin
      m_mode = M_HOLD;
    end else if (m_mode == M_HOLD) begin
      if (fe) begin
        m_mode = M_SETTLE;
        m_left = SETTLE_FRAMES;
        req = 1'b1;
      end
    end else if (rel) begin
      m_mode = M_SETTLE;
      m_left = SETTLE_FRAMES;
    end else if (fe && m_mode == M_SETTLE) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = M_RUN;
        m_frames = 0;
      end
    end else if (fe && m_mode == M_RUN) begin
      if (m_frames < 255) m_frames++;
    end
    if (req) m_pulse = RST_LEN;
    else if (m_pulse > 0) m_pulse--;
  endfunction

  // driver tasks
  task automatic tick();
    if (!nRST) model_reset();
    exp_q.push_back(model_out());
    if (nRST) model_edge();
    @(posedge VCLK);
    #1;
  endtask

  int wr_at = -1;
  int wr2_at = -1;
  int mode_at = -1;
  int rst_at = -1;
  logic [15:0] wr_dat = 16'h0000;
  logic [15:0] wr2_dat = 16'h0000;
  logic mode_val = 1'b0;
  int low_cnt;
  int saved_fc;

  // One frame: the first sync word carries the vsync falling edge (fe on cycle 0).
  task automatic frame(input int len);
    low_cnt = 0;
    for (int i = 0; i < len; i++) begin
      nVDSYNC = (i == 0 || i == len - 1) ? 1'b0 : (($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1);
      if (!nVDSYNC) nVSYNC_i = (i < 3) ? 1'b0 : 1'b1;
      else nVSYNC_i = 1'($urandom_range(0, 1));
      cfg_wr_i = (i == wr_at) || (i == wr2_at);
      cfg_data_i = (i == wr_at) ? wr_dat : ((i == wr2_at) ? wr2_dat : 16'($urandom));
      if (i == mode_at) n64_480i = mode_val;
      if (i == rst_at) nRST = 1'b0;
      if (i == rst_at + 2) nRST = 1'b1;
      tick();
      if (i < 8 && !nrst_alg_o) low_cnt++;
    end
    nVDSYNC = 1'b1;
    cfg_wr_i = 1'b0;
    wr_at = -1;
    wr2_at = -1;
    mode_at = -1;
    rst_at = -1;
  endtask

  initial begin
    int len;
    model_reset();
    @(posedge VCLK);
    #1;
    repeat (3) tick();
    check("reset nrst_alg_o", {15'd0, nrst_alg_o}, 16'd0);
    check("reset settings_o", settings_o, 16'h0000);
    check("reset est_enable_o", {15'd0, est_enable_o}, 16'd0);
    check("reset frame_cnt_o", {8'd0, frame_cnt_o}, 16'd0);
    check("reset cfg_pending_o", {15'd0, cfg_pending_o}, 16'd0);

    // power-up sequence
    nRST = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (!nrst_alg_o) low_cnt++;
      tick();
    end
    check("release pulse length", 16'(low_cnt), 16'd4);
    frame(40);
    check("first fe pulse length", 16'(low_cnt), 16'd4);
    check("settle est_enable 1", {15'd0, est_enable_o}, 16'd0);
    frame(40);
    check("settle est_enable 2", {15'd0, est_enable_o}, 16'd0);
    frame(40);
    check("run est_enable", {15'd0, est_enable_o}, 16'd1);
    check("run entry frame_cnt", {8'd0, frame_cnt_o}, 16'd0);
    frame(40);
    check("first run frame_cnt", {8'd0, frame_cnt_o}, 16'd1);

    // config apply
    wr_at = 10; wr_dat = 16'h0A31;
    frame(40);
    check("pending before fe", {15'd0, cfg_pending_o}, 16'd1);
    check("settings before fe", settings_o, 16'h0000);
    frame(40);
    check("apply 0A31", settings_o, 16'h0A31);
    check("pending after apply", {15'd0, cfg_pending_o}, 16'd0);
    check("apply 0A31 pulse", 16'(low_cnt), 16'd4);
    wr_at = 5; wr_dat = 16'h0B31; wr2_at = 20; wr2_dat = 16'h0A32;
    frame(40);
    frame(40);
    check("last write wins", settings_o, 16'h0A32);
    check("low-bit change no pulse", 16'(low_cnt), 16'd0);

    // write coincident with fe
    wr_at = 10; wr_dat = 16'h0A31;
    frame(40);
    wr_at = 0; wr_dat = 16'h1234;
    frame(40);
    check("coincident applies old shadow", settings_o, 16'h0A31);
    check("coincident stays pending", {15'd0, cfg_pending_o}, 16'd1);
    frame(40);
    check("next fe applies 1234", settings_o, 16'h1234);
    frame(40);
    frame(40);
    check("back in run", {15'd0, est_enable_o}, 16'd1);

    // relevant change in run
    wr_at = 10; wr_dat = 16'h0234;
    frame(40);
    frame(40);
    check("bit12 change pulse", 16'(low_cnt), 16'd4);
    check("bit12 change est drop", {15'd0, est_enable_o}, 16'd0);
    frame(40);
    check("still settling", {15'd0, est_enable_o}, 16'd0);
    frame(40);
    check("run after 2 fe", {15'd0, est_enable_o}, 16'd1);
    wr_at = 10; wr_dat = 16'h0235;
    frame(40);
    frame(40);
    check("bit0 change no pulse", 16'(low_cnt), 16'd0);
    check("bit0 change stays run", {15'd0, est_enable_o}, 16'd1);
    check("bit0 applied", settings_o, 16'h0235);

    // mode switch
    mode_at = 15; mode_val = 1'b1;
    frame(40);
    check("480i est off", {15'd0, est_enable_o}, 16'd0);
    saved_fc = m_frames;
    frame(40);
    check("480i frame_cnt frozen", {8'd0, frame_cnt_o}, 16'(saved_fc));
    mode_at = 20; mode_val = 1'b0;
    frame(40);
    frame(40);
    check("240p re-entry pulse", 16'(low_cnt), 16'd4);
    frame(40);
    frame(40);
    check("re-entry run", {15'd0, est_enable_o}, 16'd1);
    repeat (300) frame(8);
    check("frame_cnt saturates", {8'd0, frame_cnt_o}, 16'h00FF);

    // reset during pulse with shadow pending
    wr_at = 3; wr_dat = 16'h5A5A;
    frame(40);
    wr_at = 1; wr_dat = 16'h1111; rst_at = 2;
    frame(40);
    check("mid reset pending lost", {15'd0, cfg_pending_o}, 16'd0);
    check("mid reset settings", settings_o, 16'h0000);
    check("mid reset est", {15'd0, est_enable_o}, 16'd0);
    check("mid reset frame_cnt", {8'd0, frame_cnt_o}, 16'd0);
    frame(40);
    check("post reset hold->settle pulse", 16'(low_cnt), 16'd4);
    check("post reset settings", settings_o, 16'h0000);

    // randomized traffic
    repeat (150) begin
      len = $urandom_range(6, 30);
      if ($urandom_range(0, 1) == 1) begin
        wr_at = $urandom_range(0, len - 1);
        wr_dat = ($urandom_range(0, 2) == 0) ? (m_shadow ^ 16'($urandom_range(0, 3))) : 16'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        mode_at = $urandom_range(0, len - 1);
        mode_val = ~n64_480i;
      end
      frame(len);
    end

    repeat (2) tick();
    @(negedge VCLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/n64a_deblur_sched.md
Name: n64a_deblur_sched

Overview:
Frame-synchronous controller for the VI-deblur estimator. Receives deblur algorithm settings from the config path and double-buffers them. It applies new settings only at a frame start and issues algorithm-reset pulses. It also decides when the estimator may run: it holds the estimator off in 480i and for a settle window after a mode or settings change. The block sits between the config register block and the deblur estimator on the VCLK domain.

Parameters:
SETTLE_FRAMES, 2, frames to discard after entering 240p or after a relevant settings change (legal range 1..15)
RST_LEN, 4, VCLK cycles that nrst_alg_o is held low per algorithm-reset request (legal range 1..15)

Ports:
VCLK  input  1  video clock
nRST  input  1  asynchronous active-low reset
nVDSYNC  input  1  low marks sync/control-word cycle of the VI bus
nVSYNC_i  input  1  vertical sync bit of the VI sync word; valid only when nVDSYNC=0
n64_480i  input  1  1 = interlaced mode
cfg_wr_i  input  1  single-cycle write strobe
cfg_data_i  input  16  new algorithm settings word, same bit layout as the estimator settings
cfg_pending_o  output  1  shadow written but not yet applied
settings_o  output  16  active settings driven to the estimator
nrst_alg_o  output  1  active-low algorithm reset to the estimator
est_enable_o  output  1  estimator may accumulate this frame
frame_cnt_o  output  8  saturating count of frames spent in RUN

Behaviour:
- Clock, reset and interface: one clock (VCLK). Reset nRST is asynchronous and active-low.
- Reset values: settings_o=16'h0000, shadow=0, cfg_pending_o=0, nrst_alg_o=0 released to 1 after RST_LEN cycles, est_enable_o=0, frame_cnt_o=0, state=HOLD, sampled nVSYNC=1.
- Frame event (fe):
  - nVSYNC_i is registered only on cycles with nVDSYNC=0.
  - fe is a one-cycle internal pulse on an nVDSYNC=0 cycle where the registered value is 1 and nVSYNC_i is 0.
  - All state updates below that say "at fe" occur on that clock edge.
- Config handshake:
  - cfg_wr_i=1 loads shadow<=cfg_data_i and sets pending=1. Last write wins; writes are never dropped.
  - At fe with pending=1: settings_o<=shadow and pending<=0, unless cfg_wr_i=1 in the same cycle.
  - Simultaneous cfg_wr_i and fe: the previous shadow is applied (if pending). The new word is stored and remains pending for the next fe.
- Relevant change: an apply where settings_o[14:8] or settings_o[5:2] differ between the old and new word. Changes confined to bits [1:0] or bits 7:6/15 are not relevant.
- Algorithm reset request raised by any of:
  - a relevant change;
  - a HOLD->SETTLE transition.
  - Effect: nrst_alg_o goes 0 on the next cycle for exactly RST_LEN cycles.
  - A new request during an active pulse reloads the counter to RST_LEN (extends the pulse).
- State machine (2-bit):
  - HOLD: est_enable_o=0. At fe with n64_480i=0: go to SETTLE, settle_cnt<=0, request reset.
  - SETTLE: est_enable_o=0. At fe: settle_cnt++. When settle_cnt reaches SETTLE_FRAMES-1 at fe, go to RUN and clear frame_cnt_o.
  - RUN: est_enable_o=1. At fe: frame_cnt_o++, saturating at 8'hFF.
  - n64_480i=1 in any state, on any cycle: go to HOLD next cycle and clear est_enable_o. frame_cnt_o is held.
  - Relevant change at fe while in SETTLE or RUN (and n64_480i=0): go to SETTLE, settle_cnt<=0. The reset request is already raised.
  - Priority: n64_480i > relevant change > counter progress.
- est_enable_o and frame_cnt_o are registered, with 1-cycle latency from the decision edge.
- Reset mid-operation: all registers return to reset values immediately, including any pending shadow and the nrst_alg_o pulse. The pulse restarts after release.

Test Plan:
1. Power-up, n64_480i=0, frames every 1000 cycles:
   - nrst_alg_o low for 4 cycles after nRST release and again after the 1st fe.
   - est_enable_o=1 after the 2nd subsequent fe (SETTLE_FRAMES=2).
   - frame_cnt_o=1 after the next fe.
2. Config apply:
   - cfg_wr_i with 16'h0A31 mid-frame: cfg_pending_o=1 and settings_o unchanged until fe; settings_o=16'h0A31 and pending=0 the cycle after fe.
   - A second write of 16'h0A32 before fe: 16'h0A32 is applied instead.
3. Simultaneous cfg_wr_i (16'h1234) and fe with pending shadow 16'h0A31: settings_o=16'h0A31 and cfg_pending_o stays 1. The next fe applies 16'h1234.
4. Relevant change:
   - In RUN, apply a word differing in bit 12: nrst_alg_o pulses 4 cycles, est_enable_o drops, and RUN returns after 2 fe.
   - Changing only bit 0: no pulse, state stays RUN.
5. Mode switch:
   - n64_480i rises mid-frame in RUN: est_enable_o=0 the next cycle, frame_cnt_o frozen.
   - n64_480i falls: at the next fe, a reset pulse and SETTLE.
   - Frame counter saturation: 300 fe in RUN leaves frame_cnt_o=8'hFF.
6. Reset mid-pulse and mid-pending: assert nRST during the nrst_alg_o pulse with shadow pending. All outputs return to reset values, pending is lost, and a fresh 4-cycle pulse follows release.
